// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes and controller states.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mau_state_e;

endpackage

// File: rtl/load_align.sv
// Load formatter: picks the addressed byte/half lane from a bus word and extends it to 32 bits.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] RData,
    input  logic [1:0]  ByteOffset,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    output logic [31:0] Data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = RData[7:0];
        case (ByteOffset)
            2'd1:    byte_sel = RData[15:8];
            2'd2:    byte_sel = RData[23:16];
            2'd3:    byte_sel = RData[31:24];
            default: byte_sel = RData[7:0];
        endcase
        half_sel = ByteOffset[1] ? RData[31:16] : RData[15:0];

        Data = RData;
        case (mem_size_e'(Size))
            SIZE_HALF: Data = {{16{SignExt & half_sel[15]}}, half_sel};
            SIZE_BYTE: Data = {{24{SignExt & byte_sel[7]}}, byte_sel};
            default:   Data = RData;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues req/ack data-memory accesses, stalls the pipeline until
// completion, formats load data and flags misaligned accesses and bus timeouts.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MemRead_In,
    input  logic              MemWrite_In,
    input  logic [1:0]        MemSize_In,
    input  logic              MemSignExt_In,
    input  logic [DATA_W-1:0] Address_In,
    input  logic [DATA_W-1:0] WriteData_In,
    output logic              MemReq,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemAddr,
    output logic [3:0]        MemByteEn,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck,
    output logic [DATA_W-1:0] ReadData_Out,
    output logic              Stall,
    output logic              MisalignedExc,
    output logic              BusError
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mau_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mis_q, mis_d;
    logic             berr_q, berr_d;
    // Load formatting context, captured at issue so it does not rely on EX/MEM holding.
    logic             load_q, load_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             sext_q, sext_d;

    mem_size_e   size_in;
    logic        access;
    logic        aligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] load_data;

    load_align u_load_align (
        .RData      (MemRData),
        .ByteOffset (off_q),
        .Size       (size_q),
        .SignExt    (sext_q),
        .Data       (load_data)
    );

    always_comb begin
        size_in = mem_size_e'(MemSize_In);
        access  = MemRead_In | MemWrite_In;

        aligned  = (Address_In[1:0] == 2'b00);
        st_be    = 4'b1111;
        st_wdata = WriteData_In;
        case (size_in)
            SIZE_HALF: begin
                aligned  = ~Address_In[0];
                st_be    = Address_In[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{WriteData_In[15:0]}};
            end
            SIZE_BYTE: begin
                aligned  = 1'b1;
                st_be    = 4'b0001 << Address_In[1:0];
                st_wdata = {4{WriteData_In[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        load_d  = load_q;
        off_d   = off_q;
        size_d  = size_q;
        sext_d  = sext_q;
        Stall   = 1'b0;

        case (state_q)
            IDLE: begin
                if (access && !aligned) begin
                    mis_d   = 1'b1;
                    rdata_d = '0;
                end else if (access) begin
                    Stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = MemWrite_In;
                    addr_d  = {Address_In[31:2], 2'b00};
                    be_d    = MemWrite_In ? st_be : 4'b1111;
                    wdata_d = MemWrite_In ? st_wdata : '0;
                    load_d  = ~MemWrite_In;
                    off_d   = Address_In[1:0];
                    size_d  = MemSize_In;
                    sext_d  = MemSignExt_In;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (MemAck) begin
                    req_d = 1'b0;
                    if (load_q) rdata_d = load_data;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            load_q  <= 1'b0;
            off_q   <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            load_q  <= load_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
        end
    end

    assign MemReq        = req_q;
    assign MemWe         = we_q;
    assign MemAddr       = addr_q;
    assign MemByteEn     = be_q;
    assign MemWData      = wdata_q;
    assign ReadData_Out  = rdata_q;
    assign MisalignedExc = mis_q;
    assign BusError      = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout and mid-access reset.
module tb_mem_access_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        MemRead_In, MemWrite_In, MemSignExt_In, MemAck;
    logic [1:0]  MemSize_In;
    logic [31:0] Address_In, WriteData_In, MemRData;
    logic        MemReq, MemWe, Stall, MisalignedExc, BusError;
    logic [31:0] MemAddr, MemWData, ReadData_Out;
    logic [3:0]  MemByteEn;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    mem_access_unit #(.TIMEOUT_CYCLES(16), .DATA_W(32)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .MemRead_In    (MemRead_In),
        .MemWrite_In   (MemWrite_In),
        .MemSize_In    (MemSize_In),
        .MemSignExt_In (MemSignExt_In),
        .Address_In    (Address_In),
        .WriteData_In  (WriteData_In),
        .MemReq        (MemReq),
        .MemWe         (MemWe),
        .MemAddr       (MemAddr),
        .MemByteEn     (MemByteEn),
        .MemWData      (MemWData),
        .MemRData      (MemRData),
        .MemAck        (MemAck),
        .ReadData_Out  (ReadData_Out),
        .Stall         (Stall),
        .MisalignedExc (MisalignedExc),
        .BusError      (BusError)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Runs one access from IDLE; ack_idx is the 0-based WAIT cycle carrying MemAck (-1 = never).
    // Returns with the DUT in its DONE cycle and the access inputs dropped.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                              input int ack_idx, output int stalls, output logic [31:0] c_addr,
                              output logic [3:0] c_be, output logic [31:0] c_wd, output logic c_we,
                              output logic unstable, output logic berr);
        int widx;
        MemRead_In = rd; MemWrite_In = wr; MemSize_In = sz; MemSignExt_In = sx;
        Address_In = addr; WriteData_In = wd;
        #1;
        stalls = 0; widx = 0; unstable = 1'b0; berr = 1'b0;
        c_addr = '0; c_be = '0; c_wd = '0; c_we = 1'b0;
        for (int cyc = 0; cyc < 64 && Stall; cyc++) begin
            stalls++;
            step();
            MemAck = 1'b0;
            if (Stall) begin
                if (!MemReq) unstable = 1'b1;
                if (widx == 0) begin
                    c_addr = MemAddr; c_be = MemByteEn; c_wd = MemWData; c_we = MemWe;
                end else if (MemAddr !== c_addr || MemByteEn !== c_be ||
                             MemWData !== c_wd || MemWe !== c_we) begin
                    unstable = 1'b1;
                end
                if (widx == ack_idx) begin
                    MemAck = 1'b1;
                    MemRData = rdat;
                end
                widx++;
            end
        end
        berr = BusError;
        MemRead_In = 1'b0; MemWrite_In = 1'b0;
        #1;
        check("done_req_low", {31'd0, MemReq}, 32'd0);
    endtask

    int          st;
    logic [31:0] ca, cw;
    logic [3:0]  cb;
    logic        cwe, uns, be;

    initial begin
        Reset = 1'b1; MemRead_In = 1'b0; MemWrite_In = 1'b0; MemSize_In = 2'b00;
        MemSignExt_In = 1'b0; Address_In = '0; WriteData_In = '0; MemRData = '0; MemAck = 1'b0;
        step(); step();
        check("rst_req",   {31'd0, MemReq}, 32'd0);
        check("rst_be",    {28'd0, MemByteEn}, 32'd0);
        check("rst_addr",  MemAddr, 32'd0);
        check("rst_rdata", ReadData_Out, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_exc",   {30'd0, MisalignedExc, BusError}, 32'd0);
        Reset = 1'b0;
        step();

        // word load, ack on first WAIT cycle
        run_access(1, 0, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, st, ca, cb, cw, cwe, uns, be);
        check("wl_addr",   ca, 32'h100);
        check("wl_be",     {28'd0, cb}, 32'hF);
        check("wl_we",     {31'd0, cwe}, 32'd0);
        check("wl_stalls", st, 2);
        check("wl_rdata",  ReadData_Out, 32'hDEADBEEF);
        check("wl_stall0", {31'd0, Stall}, 32'd0);
        step();

        // byte load lane 3, signed then unsigned
        run_access(1, 0, 2'b10, 1, 32'h103, 32'h0, 32'h80FF1234, 0, st, ca, cb, cw, cwe, uns, be);
        check("bls_addr",  ca, 32'h100);
        check("bls_rdata", ReadData_Out, 32'hFFFFFF80);
        step();
        run_access(1, 0, 2'b10, 0, 32'h103, 32'h0, 32'h80FF1234, 0, st, ca, cb, cw, cwe, uns, be);
        check("blu_rdata", ReadData_Out, 32'h00000080);
        step();

        // half loads: upper half signed, lower half zero-extended
        run_access(1, 0, 2'b01, 1, 32'h106, 32'h0, 32'h80017FFF, 1, st, ca, cb, cw, cwe, uns, be);
        check("hls_rdata", ReadData_Out, 32'hFFFF8001);
        step();
        run_access(1, 0, 2'b01, 0, 32'h104, 32'h0, 32'h1234F00D, 0, st, ca, cb, cw, cwe, uns, be);
        check("hlu_rdata", ReadData_Out, 32'h0000F00D);
        step();

        // half store at 0x0A, ack in third WAIT cycle; ReadData_Out must keep 0x0000F00D
        run_access(0, 1, 2'b01, 0, 32'h0A, 32'h0000ABCD, 32'h55555555, 2, st, ca, cb, cw, cwe, uns, be);
        check("hs_we",     {31'd0, cwe}, 32'd1);
        check("hs_addr",   ca, 32'h08);
        check("hs_be",     {28'd0, cb}, 32'hC);
        check("hs_wdata",  cw, 32'hABCDABCD);
        check("hs_stalls", st, 4);
        check("hs_stable", {31'd0, uns}, 32'd0);
        check("hs_rdata",  ReadData_Out, 32'h0000F00D);
        step();

        // byte store lane 1 and word store
        run_access(0, 1, 2'b10, 0, 32'h201, 32'h1234565A, 32'h0, 0, st, ca, cb, cw, cwe, uns, be);
        check("bs_be",    {28'd0, cb}, 32'h2);
        check("bs_wdata", cw, 32'h5A5A5A5A);
        step();
        run_access(0, 1, 2'b00, 0, 32'h300, 32'hCAFEF00D, 32'h0, 0, st, ca, cb, cw, cwe, uns, be);
        check("ws_be",    {28'd0, cb}, 32'hF);
        check("ws_wdata", cw, 32'hCAFEF00D);
        step();

        // misaligned word load
        MemRead_In = 1'b1; MemSize_In = 2'b00; Address_In = 32'h102;
        #1;
        check("mis_stall", {31'd0, Stall}, 32'd0);
        step();
        check("mis_exc",   {31'd0, MisalignedExc}, 32'd1);
        check("mis_req",   {31'd0, MemReq}, 32'd0);
        check("mis_rdata", ReadData_Out, 32'd0);
        MemRead_In = 1'b0;
        step();
        check("mis_pulse", {31'd0, MisalignedExc}, 32'd0);

        // timeout: no ack ever
        run_access(1, 0, 2'b00, 0, 32'h104, 32'h0, 32'h0, -1, st, ca, cb, cw, cwe, uns, be);
        check("to_stalls", st, 17);
        check("to_berr",   {31'd0, be}, 32'd1);
        check("to_rdata",  ReadData_Out, 32'd0);
        step();
        check("to_pulse",  {31'd0, BusError}, 32'd0);
        check("to_idle",   {31'd0, Stall}, 32'd0);

        // reset during WAIT, late ack afterwards
        MemRead_In = 1'b1; MemSize_In = 2'b00; Address_In = 32'h400;
        step();
        check("rw_req", {31'd0, MemReq}, 32'd1);
        Reset = 1'b1;
        step();
        check("rw_req_rst", {31'd0, MemReq}, 32'd0);
        Reset = 1'b0; MemRead_In = 1'b0; MemAck = 1'b1; MemRData = 32'h11111111;
        step();
        MemAck = 1'b0;
        check("rw_req_late", {31'd0, MemReq}, 32'd0);
        check("rw_rdata",    ReadData_Out, 32'd0);
        check("rw_stall",    {31'd0, Stall}, 32'd0);
        run_access(1, 0, 2'b00, 0, 32'h500, 32'h0, 32'h0BADF00D, 0, st, ca, cb, cw, cwe, uns, be);
        check("rw_after_st",    st, 2);
        check("rw_after_rdata", ReadData_Out, 32'h0BADF00D);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller that sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a variable-latency data-memory bus using a req/ack handshake, and generates store byte enables with lane-replicated write data.
- Aligns and sign- or zero-extends load data, producing the ReadData input of MEM/WB.
- Asserts Stall so the pipeline holds, and MEM/WB WriteEnable drops, until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16: max WAIT cycles before an access is aborted with BusError.
- DATA_W, 32: data and address width. Fixed at 32; present for documentation.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- MemRead_In  in  1  load in MEM stage.
- MemWrite_In  in  1  store in MEM stage.
- MemSize_In  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- MemSignExt_In  in  1  1 = sign-extend loaded byte/half, 0 = zero-extend.
- Address_In  in  32  byte address (ALU result).
- WriteData_In  in  32  store data, LSB-justified.
- MemReq  out  1  bus request, registered.
- MemWe  out  1  1 = write, registered.
- MemAddr  out  32  word-aligned address ({Address_In[31:2],2'b00}), registered.
- MemByteEn  out  4  lane enables, registered.
- MemWData  out  32  replicated store data, registered.
- MemRData  in  32  read data, valid when MemAck=1.
- MemAck  in  1  access complete.
- ReadData_Out  out  32  formatted load data, registered.
- Stall  out  1  hold PC/IF/ID/EX/EXMEM; MEMWB WriteEnable = ~Stall.
- MisalignedExc  out  1  one-cycle pulse on a misaligned access.
- BusError  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (synchronous): state=IDLE, timeout counter=0. MemReq, MemWe, MemAddr, MemByteEn, MemWData, ReadData_Out, MisalignedExc and BusError all go to 0. Stall=0 while in IDLE with no access pending.
- A reset mid-access abandons the access. Any late MemAck is ignored because it is only sampled in WAIT.
- Access = MemRead_In | MemWrite_In. If both are set, write wins.
- Alignment:
  - word requires Address_In[1:0]==0
  - half requires Address_In[0]==0
  - byte is always aligned
- State IDLE:
  - No access: Stall=0, stay in IDLE.
  - Misaligned access: no request. MisalignedExc=1 for one cycle, ReadData_Out<=0, Stall=0, stay in IDLE.
  - Aligned access: Stall=1 (combinational). Load MemReq=1, MemWe, MemAddr, MemByteEn and MemWData at the edge. Clear the counter. Go to WAIT.
- State WAIT:
  - Stall=1. MemReq and bus fields are held stable.
  - MemAck=1: MemReq<=0. For a load, ReadData_Out<=formatted MemRData; for a store, ReadData_Out is unchanged. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: MemReq<=0, BusError=1 for one cycle, ReadData_Out<=0, go to DONE.
  - Otherwise the counter increments.
- State DONE:
  - Stall=0 for exactly one cycle so the pipeline and MEM/WB advance. No new request is issued.
  - Next state is IDLE, which prevents re-issuing the same instruction.
- Minimum latency with ack on the first WAIT cycle: issue edge, ack edge, DONE cycle. That is 2 stall cycles plus 1 advance cycle.
- Byte lanes are little-endian; lane k = bits[8k+7:8k], with k = Address_In[1:0].
- Stores:
  - byte: ByteEn = 4'b0001<<k; WData = {4{WriteData_In[7:0]}}
  - half: ByteEn = Address_In[1] ? 4'b1100 : 4'b0011; WData = {2{WriteData_In[15:0]}}
  - word: ByteEn = 4'b1111; WData = WriteData_In
- Loads: select the lane (byte) or half (by Address_In[1]). Extend to 32 bits per MemSignExt_In. Word loads pass through.
- MemByteEn for a load is 4'b1111.

Decomposition:
- Shared package mips_mem_pkg holds the MemSize encodings (SIZE_WORD, SIZE_HALF, SIZE_BYTE) and the FSM state encoding (IDLE/WAIT/DONE).
- One combinational sub-module, load_align, with inputs RData, ByteOffset[1:0], Size and SignExt, and output Data[31:0]. The store lane logic stays inline.

Test Plan:
- Word load, addr 0x100, MemRData=0xDEADBEEF, ack on the 1st WAIT cycle → MemAddr=0x100, ByteEn=1111, Stall high 2 cycles then low 1, ReadData_Out=0xDEADBEEF.
- Byte load, addr 0x103, signed, MemRData=0x80FF1234 → ReadData_Out=0xFFFFFF80. Unsigned → 0x00000080.
- Half store, addr 0x0A, WriteData_In=0x0000ABCD, ack after 3 WAIT cycles → MemWe=1, MemAddr=0x08, ByteEn=1100, WData=0xABCDABCD, Stall high 4 cycles, MemReq stable throughout.
- Word load at addr 0x102 → no MemReq, MisalignedExc pulse, Stall=0, ReadData_Out=0.
- Load with no ack, TIMEOUT_CYCLES=16 → BusError pulses after 16 WAIT cycles, ReadData_Out=0, MemReq drops, DONE then IDLE.
- Reset asserted during WAIT, then MemAck arrives the cycle after reset → state IDLE, MemReq=0, ReadData_Out unchanged at 0, no DONE cycle.
